// File: rtl/fpu_seq_ctrl.sv
// Sequencer for multi-cycle FPU ops: stalls the pipeline for each op's programmed latency,
// launches the FPU with a one-cycle pulse, and flags writeback of the captured destination.
module fpu_seq_ctrl #(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_CVT  = 1,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [3:0] fpuop,
    input  logic [4:0] rd_addr,
    input  logic       rdflag,
    input  logic       flush,
    output logic       stall,
    output logic       busy,
    output logic       fpu_start,
    output logic [3:0] fpu_op,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_rdflag,
    output logic       illegal_op
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] op_lat;
    logic             op_unknown;
    logic             accept;

    always_comb begin
        op_lat = '0;
        case (fpuop)
            4'b0000, 4'b0001: op_lat = CNT_W'(LAT_ADD);
            4'b0010:          op_lat = CNT_W'(LAT_MUL);
            4'b0011:          op_lat = CNT_W'(LAT_DIV);
            4'b0100:          op_lat = CNT_W'(LAT_SQRT);
            4'b1011, 4'b1100: op_lat = CNT_W'(LAT_CVT);
            default:          op_lat = '0;
        endcase
    end

    assign op_unknown = (fpuop > 4'd12);

    // New ops are taken in IDLE and also in WB, so back-to-back ops lose no cycle.
    assign accept   = issue_valid & ~flush & (op_lat != '0) & (state != RUN);
    assign stall    = (state == RUN) | accept;
    assign busy     = (state != IDLE);
    assign wb_valid = (state == WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            fpu_op     <= '0;
            wb_rd      <= '0;
            wb_rdflag  <= 1'b0;
            fpu_start  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            fpu_start  <= 1'b0;
            // Issue is ignored while RUN holds the pipeline, so no illegal report then either.
            illegal_op <= issue_valid & ~flush & (state != RUN) & op_unknown;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    RUN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= WB;
                        end
                    end
                    default: begin
                        if (accept) begin
                            state     <= RUN;
                            cnt       <= op_lat;
                            fpu_op    <= fpuop;
                            wb_rd     <= rd_addr;
                            wb_rdflag <= rdflag;
                            fpu_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: directed vector table, reset-mid-run sequence, and random issue
// traffic checked against a timeline model of the op schedule.
module tb_fpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [3:0] fpuop;
    logic [4:0] rd_addr;
    logic       rdflag;
    logic       flush;
    logic       stall, busy, fpu_start, wb_valid, wb_rdflag, illegal_op;
    logic [3:0] fpu_op;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    fpu_seq_ctrl dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .fpuop(fpuop), .rd_addr(rd_addr),
        .rdflag(rdflag), .flush(flush), .stall(stall), .busy(busy), .fpu_start(fpu_start),
        .fpu_op(fpu_op), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rdflag(wb_rdflag),
        .illegal_op(illegal_op)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Latency of each fpuop encoding, indexed by opcode.
    int lat_tab [16] = '{2, 2, 2, 8, 8, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

    // Timeline model: an accepted op at cycle T writes back at T+lat+1.
    bit         m_active;
    int         m_wb_cyc;
    bit         m_start;
    bit         m_ill;
    logic [3:0] m_op;
    logic [4:0] m_rd;
    logic       m_rf;
    int         cyc;

    logic       s_stall, s_busy, s_start, s_wb, s_ill;
    logic [4:0] s_rd;

    typedef struct {
        logic       iv;
        logic [3:0] op;
        logic [4:0] rd;
        logic       rf;
        logic       fl;
        logic       e_stall;
        logic       e_busy;
        logic       e_start;
        logic       e_wb;
        logic [4:0] e_rd;
        logic       e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_start  = 0;
        m_ill    = 0;
        m_op     = '0;
        m_rd     = '0;
        m_rf     = 1'b0;
        cyc      = 0;
    endtask

    // Called just after a posedge: drive inputs, check at negedge, return just after next posedge.
    task automatic step(input logic iv, input logic [3:0] op, input logic [4:0] rd,
                        input logic rf, input logic fl);
        bit in_run, in_wb, acc;
        int l;
        issue_valid = iv;
        fpuop       = op;
        rd_addr     = rd;
        rdflag      = rf;
        flush       = fl;
        @(negedge clk);
        s_stall = stall;
        s_busy  = busy;
        s_start = fpu_start;
        s_wb    = wb_valid;
        s_rd    = wb_rd;
        s_ill   = illegal_op;
        l      = lat_tab[op];
        in_run = m_active && (cyc < m_wb_cyc);
        in_wb  = m_active && (cyc == m_wb_cyc);
        acc    = iv && !fl && (l != 0) && !in_run;
        check("model_stall", 32'(stall), 32'(in_run || acc));
        check("model_busy", 32'(busy), 32'(in_run || in_wb));
        check("model_wb_valid", 32'(wb_valid), 32'(in_wb));
        check("model_fpu_start", 32'(fpu_start), 32'(m_start));
        check("model_illegal", 32'(illegal_op), 32'(m_ill));
        check("model_fpu_op", 32'(fpu_op), 32'(m_op));
        check("model_wb_rd", 32'(wb_rd), 32'(m_rd));
        check("model_wb_rdflag", 32'(wb_rdflag), 32'(m_rf));
        m_start = acc;
        m_ill   = iv && !fl && !in_run && (op >= 4'd13);
        if (fl) begin
            m_active = 0;
        end else if (acc) begin
            m_active = 1;
            m_wb_cyc = cyc + l + 1;
            m_op     = op;
            m_rd     = rd;
            m_rf     = rf;
        end else if (in_wb) begin
            m_active = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic iv, input logic [3:0] op, input logic [4:0] rd, input logic rf,
                           input logic fl, input logic es, input logic eb, input logic est,
                           input logic ew, input logic [4:0] er, input logic ei);
        vecs.push_back('{iv, op, rd, rf, fl, es, eb, est, ew, er, ei});
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 0; fpuop = '0; rd_addr = '0; rdflag = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_wb_valid", 32'(wb_valid), 0);
        check("reset_fpu_start", 32'(fpu_start), 0);
        check("reset_fpu_op", 32'(fpu_op), 0);
        check("reset_wb_rd", 32'(wb_rd), 0);
        check("reset_illegal", 32'(illegal_op), 0);
        rst = 1'b0;
        model_reset();

        // fadd rd=5 float: stall T..T+2, start T+1, writeback T+3
        add_vec(1, 4'd0, 5'd5, 1, 0,  1, 0, 0, 0, 5'd0, 0);
        add_vec(1, 4'd0, 5'd5, 1, 0,  1, 1, 1, 0, 5'd5, 0);
        add_vec(1, 4'd0, 5'd5, 1, 0,  1, 1, 0, 0, 5'd5, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 1, 0, 1, 5'd5, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 0, 0, 0, 5'd5, 0);
        // pass-through fsgnj and feq
        add_vec(1, 4'd5, 5'd1, 0, 0,  0, 0, 0, 0, 5'd5, 0);
        add_vec(1, 4'd8, 5'd2, 0, 0,  0, 0, 0, 0, 5'd5, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 0, 0, 0, 5'd5, 0);
        // unknown op 1111: illegal pulse in the following cycle only
        add_vec(1, 4'd15, 5'd4, 1, 0, 0, 0, 0, 0, 5'd5, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 0, 0, 0, 5'd5, 1);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 0, 0, 0, 5'd5, 0);
        // fmul rd=3, then fcvt.s.w rd=7 accepted in the WB cycle
        add_vec(1, 4'd2, 5'd3, 1, 0,  1, 0, 0, 0, 5'd5, 0);
        add_vec(1, 4'd2, 5'd3, 1, 0,  1, 1, 1, 0, 5'd3, 0);
        add_vec(1, 4'd2, 5'd3, 1, 0,  1, 1, 0, 0, 5'd3, 0);
        add_vec(1, 4'd12, 5'd7, 0, 0, 1, 1, 0, 1, 5'd3, 0);
        add_vec(1, 4'd12, 5'd7, 0, 0, 1, 1, 1, 0, 5'd7, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 1, 0, 1, 5'd7, 0);
        add_vec(0, 4'd0, 5'd0, 0, 0,  0, 0, 0, 0, 5'd7, 0);
        // fdiv rd=9 flushed at T+3: never writes back
        add_vec(1, 4'd3, 5'd9, 1, 0,  1, 0, 0, 0, 5'd7, 0);
        add_vec(1, 4'd3, 5'd9, 1, 0,  1, 1, 1, 0, 5'd9, 0);
        add_vec(1, 4'd3, 5'd9, 1, 0,  1, 1, 0, 0, 5'd9, 0);
        add_vec(1, 4'd3, 5'd9, 1, 1,  1, 1, 0, 0, 5'd9, 0);
        for (int i = 0; i < 8; i++) add_vec(0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd9, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].iv, vecs[i].op, vecs[i].rd, vecs[i].rf, vecs[i].fl);
            check($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_start", i), 32'(s_start), 32'(vecs[i].e_start));
            check($sformatf("vec%0d_wb", i), 32'(s_wb), 32'(vecs[i].e_wb));
            check($sformatf("vec%0d_wb_rd", i), 32'(s_rd), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d_illegal", i), 32'(s_ill), 32'(vecs[i].e_ill));
        end

        // fsqrt then asynchronous reset at T+4, in the middle of RUN
        step(1, 4'd4, 5'd6, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 4'd4, 5'd6, 1, 0);
        issue_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_wb_valid", 32'(wb_valid), 0);
        check("arst_fpu_op", 32'(fpu_op), 0);
        check("arst_wb_rd", 32'(wb_rd), 0);
        check("arst_wb_rdflag", 32'(wb_rdflag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(0, 4'd0, 5'd0, 0, 0);
            check("arst_no_wb", 32'(s_wb), 0);
        end

        // Random traffic against the timeline model
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
                 5'($urandom_range(0, 31)), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 10; i++) step(0, 4'd0, 5'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
